sha256_arbiter: RTL and testbench

Round-robin arbiter and sequencer sharing one `sha256` core between `NUM_REQ` requesters.
- Each requester streams a message as 512-bit blocks, marking the first and last blocks.
- The arbiter locks the core to one owner for a whole message and issues the core's `init`/`next` pulses. It waits for the core to finish each block, then returns the final digest to the owner.
- It sits between the accelerator front-ends (AXI-lite wrappers) and a single shared `sha256` instance.

---
 rtl/sha256_arbiter.sv | 158 +++++++++++++++
 tb/tb_sha256_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_arbiter.sv
// Round-robin arbiter that locks one shared sha256 core to a single requester per message,
// sequencing the core's init/next pulses and returning the final digest (or a timeout abort).
module sha256_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ-1:0]       req_first_i,
    input  logic [NUM_REQ-1:0]       req_last_i,
    input  logic [NUM_REQ*512-1:0]   req_block_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic [NUM_REQ-1:0]       rsp_valid_o,
    input  logic [NUM_REQ-1:0]       rsp_ready_i,
    output logic [255:0]             rsp_digest_o,
    output logic                     rsp_err_o,
    output logic                     core_init_o,
    output logic                     core_next_o,
    output logic [511:0]             core_block_o,
    input  logic                     core_ready_i,
    input  logic [255:0]             core_digest_i,
    input  logic                     core_digest_valid_i,
    output logic                     busy_o
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, RESP} state_t;

    state_t          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   rr_ptr;
    logic            is_first;
    logic            is_last;
    logic            wait_first;
    logic [255:0]    digest_q;
    logic            err_q;
    logic [TW-1:0]   tcnt;

    logic            found;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   src;
    logic            xfer;
    logic [511:0]    blk_in;
    logic            unused_dv;

    assign unused_dv = core_digest_valid_i;

    // First requester holding valid+first, searching upward from rr_ptr with wrap.
    always_comb begin : arb
        int idx;
        logic [IW-1:0] sel;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        sel    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            sel = IW'(idx);
            if (!found && req_valid_i[sel] && req_first_i[sel]) begin
                found  = 1'b1;
                winner = sel;
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (rst_ni) begin
            if (state == IDLE && found) req_ready_o[winner] = 1'b1;
            else if (state == HOLD)     req_ready_o[owner]  = req_valid_i[owner];
        end
    end

    assign src    = (state == HOLD) ? owner : winner;
    assign xfer   = |(req_ready_o & req_valid_i);
    assign blk_in = req_block_i[int'(src)*512 +: 512];

    always_comb begin
        rsp_valid_o = '0;
        if (state == RESP) rsp_valid_o[owner] = 1'b1;
    end

    assign rsp_digest_o = (state == RESP) ? digest_q : '0;
    assign rsp_err_o    = (state == RESP) && err_q;
    assign core_init_o  = (state == ISSUE) && is_first;
    assign core_next_o  = (state == ISSUE) && !is_first;
    assign busy_o       = (state != IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            owner        <= '0;
            rr_ptr       <= '0;
            is_first     <= 1'b0;
            is_last      <= 1'b0;
            wait_first   <= 1'b0;
            digest_q     <= '0;
            err_q        <= 1'b0;
            tcnt         <= '0;
            core_block_o <= '0;
        end else begin
            // Grant in IDLE and continuation in HOLD share one latch path; src == owner in HOLD.
            if (xfer) begin
                owner        <= src;
                core_block_o <= blk_in;
                is_first     <= req_first_i[src];
                is_last      <= req_last_i[src];
                state        <= ISSUE;
            end
            case (state)
                IDLE: ;
                ISSUE: begin
                    wait_first <= 1'b1;
                    state      <= WAIT;
                end
                WAIT: begin
                    wait_first <= 1'b0;
                    // The core still shows ready in the cycle right after the pulse.
                    if (!wait_first && core_ready_i) begin
                        if (is_last) begin
                            digest_q <= core_digest_i;
                            err_q    <= 1'b0;
                            state    <= RESP;
                        end else begin
                            tcnt  <= '0;
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!xfer) begin
                        if (TIMEOUT != 0 && tcnt == TLAST) begin
                            err_q    <= 1'b1;
                            digest_q <= '0;
                            state    <= RESP;
                        end else if (tcnt != TMAX) begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready_i[owner]) begin
                        rr_ptr <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_arbiter.sv
// Directed bench for sha256_arbiter: a behavioural SHA-256 core model behind the arbiter,
// known-answer digests, grant order, timeout abort, restart and async reset.
module tb_sha256_arbiter;

    localparam int NR  = 2;
    localparam int TO  = 8;
    localparam int LAT = 3;

    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [2047:0] KTAB = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    localparam logic [511:0] ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] M1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] M2  = {{15{32'h0}}, 32'h000001c0};
    localparam logic [255:0] ABC_D = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                      32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    localparam logic [255:0] TWO_D = {32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
                                      32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NR-1:0]        req_valid, req_first, req_last, req_ready, rsp_valid, rsp_ready;
    logic [NR*512-1:0]    req_block;
    logic [255:0]         rsp_digest, core_digest, hreg;
    logic                 rsp_err, core_init, core_next, core_ready, core_dv, busy, pend;
    logic [511:0]         core_block;
    int                   cnt;
    int                   checks = 0;
    int                   errors = 0;
    int                   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    sha256_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_first_i(req_first), .req_last_i(req_last),
        .req_block_i(req_block), .req_ready_o(req_ready),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_digest_o(rsp_digest), .rsp_err_o(rsp_err),
        .core_init_o(core_init), .core_next_o(core_next), .core_block_o(core_block),
        .core_ready_i(core_ready), .core_digest_i(core_digest),
        .core_digest_valid_i(core_dv), .busy_o(busy)
    );

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int i = 0; i < 64; i++) begin
            s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
            t1 = hh + s1 + ((e & f) ^ (~e & g)) + KTAB[2047-32*i -: 32] + w[i];
            s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
            t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    // Core model: ready stays high one cycle past the pulse, then LAT cycles busy.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_ready <= 1'b1; core_dv <= 1'b0; core_digest <= '0;
            hreg <= '0; pend <= 1'b0; cnt <= 0;
        end else begin
            pend <= core_init | core_next;
            if (core_init)      hreg <= compress(IV, core_block);
            else if (core_next) hreg <= compress(hreg, core_block);
            if (pend) begin
                core_ready <= 1'b0; core_dv <= 1'b0; cnt <= LAT;
            end else if (cnt != 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    core_ready <= 1'b1; core_dv <= 1'b1; core_digest <= hreg;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Offer a block and return the cycle of the transfer; leaves us just after the next edge.
    task automatic offer(input int r, input logic f, input logic l, input logic [511:0] blk,
                         output int t);
        req_valid[r] = 1'b1; req_first[r] = f; req_last[r] = l;
        req_block[r*512 +: 512] = blk;
        t = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready[r]) begin t = cyc; break; end
        end
        chk("grant_seen", 256'(t >= 0), 256'(1));
        @(posedge clk); #1;
        req_valid[r] = 1'b0; req_first[r] = 1'b0; req_last[r] = 1'b0;
    endtask

    task automatic wait_rsp(input int r, output int t);
        t = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rsp_valid[r]) begin t = cyc; break; end
        end
        chk("rsp_seen", 256'(t >= 0), 256'(1));
    endtask

    // Called at a negedge: accept the response on the coming edge.
    task automatic ack(input int r);
        rsp_ready[r] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[r] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t2, tr;
        req_valid = '0; req_first = '0; req_last = '0; req_block = '0; rsp_ready = '0;

        // Reset: a pending first request must not show ready.
        req_valid = 2'b01; req_first = 2'b01;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 256'(req_ready), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_core_block", 256'(core_block), 256'(0));
        chk("rst_rsp_valid", 256'(rsp_valid), 256'(0));
        req_valid = '0; req_first = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-block "abc" from requester 0.
        offer(0, 1'b1, 1'b1, ABC, t);
        @(negedge clk);
        chk("t1_init_pulse", 256'({core_init, core_next}), 256'(2'b10));
        @(negedge clk);
        chk("t1_pulse_width", 256'({core_init, core_next}), 256'(2'b00));
        wait_rsp(0, tr);
        chk("t1_rsp_latency", 256'(tr - t), 256'(7));
        chk("t1_digest", rsp_digest, ABC_D);
        chk("t1_err", 256'(rsp_err), 256'(0));
        chk("t1_core_dv", 256'(core_dv), 256'(1));
        @(negedge clk);
        chk("t1_rsp_hold", 256'(rsp_valid), 256'(2'b01));
        ack(0);
        @(negedge clk);
        chk("t1_idle", 256'({busy, rsp_valid}), 256'(0));

        // Two-block message from requester 1.
        @(posedge clk); #1;
        offer(1, 1'b1, 1'b0, M1, t);
        @(negedge clk);
        chk("t2_init", 256'({core_init, core_next}), 256'(2'b10));
        @(posedge clk); #1;
        offer(1, 1'b0, 1'b1, M2, t2);
        chk("t2_hold_entry", 256'(t2 - t), 256'(7));
        @(negedge clk);
        chk("t2_next", 256'({core_init, core_next}), 256'(2'b01));
        wait_rsp(1, tr);
        chk("t2_digest", rsp_digest, TWO_D);
        chk("t2_err", 256'(rsp_err), 256'(0));
        ack(1);

        // Restart in HOLD: second first-block issues init again.
        offer(0, 1'b1, 1'b0, M1, t);
        @(posedge clk); #1;
        offer(0, 1'b1, 1'b1, ABC, t2);
        @(negedge clk);
        chk("t5_reinit", 256'({core_init, core_next}), 256'(2'b10));
        wait_rsp(0, tr);
        chk("t5_digest", rsp_digest, ABC_D);
        ack(0);

        // Timeout: owner 1 stalls in HOLD; requester 0 is ignored meanwhile.
        offer(1, 1'b1, 1'b0, M1, t);
        req_valid[0] = 1'b1; req_first[0] = 1'b1; req_block[511:0] = ABC;
        repeat (8) @(negedge clk);
        chk("t4_hold_ignore", 256'(req_ready), 256'(0));
        req_valid[0] = 1'b0; req_first[0] = 1'b0;
        wait_rsp(1, tr);
        chk("t4_timeout_latency", 256'(tr - t), 256'(15));
        chk("t4_err", 256'(rsp_err), 256'(1));
        chk("t4_digest_zero", rsp_digest, 256'(0));
        ack(1);

        // Async reset during WAIT.
        offer(0, 1'b1, 1'b1, ABC, t);
        @(negedge clk);
        @(negedge clk);
        chk("t6_busy_before", 256'(busy), 256'(1));
        req_valid[1] = 1'b1; req_first[1] = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 256'(busy), 256'(0));
        chk("t6_req_ready", 256'(req_ready), 256'(0));
        chk("t6_core", 256'({core_init, core_next, core_block}), 256'(0));
        chk("t6_rsp", 256'({rsp_valid, rsp_err, rsp_digest}), 256'(0));

        // Round robin after reset: both request together.
        @(posedge clk); #1;
        req_valid = 2'b11; req_first = 2'b11; req_last = 2'b11; req_block = {ABC, ABC};
        rst_n = 1'b1;
        @(negedge clk);
        chk("rr_first", 256'(req_ready), 256'(2'b01));
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_rsp(0, tr);
        chk("rr_digest0", rsp_digest, ABC_D);
        chk("rr_resp_block", 256'(req_ready), 256'(0));
        ack(0);
        @(negedge clk);
        chk("rr_second", 256'(req_ready), 256'(2'b10));
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_rsp(1, tr);
        chk("rr_digest1", rsp_digest, ABC_D);
        ack(1);
        req_valid = 2'b11;
        @(negedge clk);
        chk("rr_wrap", 256'(req_ready), 256'(2'b01));
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_rsp(0, tr);
        chk("rr_wrap_digest", rsp_digest, ABC_D);
        ack(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
